// File: rtl/uart_rx_deser.sv
// ---------------------------------------------------------------------------
// uart_rx_deser
//   Receives 8N1 serial frames from the raw UART RX pin and passes each
//   byte to the register block through a one-entry valid/ready holding
//   register. It also reports framing errors and sticky overruns.
//
// Parameters
//   CLKS_PER_BIT  system clocks per bit period (at least 4)
//   HALF_BIT      clocks from start-edge detection to the start mid-point check
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   rx         raw asynchronous RX pin, idles high
//   rx_data    received byte, meaningful while rx_valid=1
//   rx_valid   holding register holds an unread byte
//   rx_ready   consumer accepts the byte (transfer when valid & ready)
//   frame_err  one-cycle pulse when a stop bit samples low
//   overrun    sticky: a completed byte was dropped because the holder was full
//   ovr_clr    one-cycle clear of overrun (a same-cycle set wins)
//   busy       receiver is in any state other than IDLE
// ---------------------------------------------------------------------------
module uart_rx_deser #(
    parameter int CLKS_PER_BIT = 104,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       ovr_clr,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             rx_s;

    // Two-flop synchroniser; only the second stage is used downstream.
    assign sync_d = {sync_q[0], rx};
    assign rx_s   = sync_q[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = ovr_q;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                // A start bit that is no longer low at its mid-point is a
                // glitch: return quietly.
                if (cnt_q == CNT_HALF) begin
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    if (rx_s) begin
                        state_d = IDLE;
                        // The slot is free if empty or being read this cycle;
                        // otherwise the held byte is kept and the new one lost.
                        if (!valid_q || rx_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BRK;
                    end
                end
            end

            BRK: begin
                // Hold off until the line returns high so a stuck-low line
                // does not look like a stream of start bits.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sync_q    <= '1;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deser
//   Self-checking bench for uart_rx_deser with CLKS_PER_BIT=16. Frames are
//   driven bit by bit; a transaction-level model predicts when each frame's
//   stop bit is sampled, what the holding register and overrun flag do, when
//   frame_err pulses and over which edges busy is high.
// ---------------------------------------------------------------------------
module tb_uart_rx_deser;

    localparam int N   = 16;
    localparam int H   = N / 2;
    localparam int LAT = 2 + H + 9 * N;
    localparam int BIG = 32'h7fff_ffff;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic       ovr_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_deser #(
        .CLKS_PER_BIT(N),
        .HALF_BIT    (H)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .ovr_clr  (ovr_clr),
        .busy     (busy)
    );

    typedef struct {
        int         e;
        logic [7:0] d;
        bit         ok;
    } ev_t;

    int         n_tests = 0;
    int         n_fail = 0;
    int         edge_n = 0;
    int         last_e0 = 0;
    ev_t        evq[$];
    bit         m_valid = 1'b0;
    bit         m_ferr = 1'b0;
    bit         m_ovr = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         just_rst = 1'b0;
    int         blo[2] = '{0, 0};
    int         bhi[2] = '{0, 0};
    int         rdy_edge = -1;
    int         clr_edge0 = -1;
    int         clr_edge1 = -1;
    bit         rand_mode = 1'b0;
    int         rise_e[$];
    logic [7:0] rise_d[$];
    int         fall_e[$];
    int         ferr_cnt = 0;
    logic       last_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic bit m_busy(input int e);
        return (e >= blo[0] && e < bhi[0]) || (e >= blo[1] && e < bhi[1]);
    endfunction

    task automatic new_busy(input int lo, input int hi);
        blo[0] = blo[1];
        bhi[0] = bhi[1];
        blo[1] = lo;
        bhi[1] = hi;
    endtask

    // One clock: update the model with the inputs seen at this edge, then
    // compare every output shortly after the edge.
    task automatic tick();
        bit  old_valid;
        ev_t ev;
        @(posedge clk);
        edge_n++;
        if (rst) begin
            m_valid  = 1'b0;
            m_data   = 8'h00;
            m_ovr    = 1'b0;
            m_ferr   = 1'b0;
            just_rst = 1'b1;
            evq.delete();
            blo = '{0, 0};
            bhi = '{0, 0};
        end else begin
            just_rst  = 1'b0;
            old_valid = m_valid;
            m_ferr    = 1'b0;
            if (old_valid && rx_ready) m_valid = 1'b0;
            if (ovr_clr) m_ovr = 1'b0;
            if (evq.size() > 0 && evq[0].e == edge_n) begin
                ev = evq.pop_front();
                if (!ev.ok) begin
                    m_ferr = 1'b1;
                end else if (!old_valid || rx_ready) begin
                    m_valid = 1'b1;
                    m_data  = ev.d;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
        #1;
        check("rx_valid", {31'd0, rx_valid}, {31'd0, m_valid});
        check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        check("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
        check("busy", {31'd0, busy}, {31'd0, m_busy(edge_n)});
        if (m_valid || just_rst) check("rx_data", {24'd0, rx_data}, {24'd0, m_data});
        if (rx_valid === 1'b1 && last_valid !== 1'b1) begin
            rise_e.push_back(edge_n);
            rise_d.push_back(rx_data);
        end
        if (rx_valid !== 1'b1 && last_valid === 1'b1) fall_e.push_back(edge_n);
        if (frame_err === 1'b1) ferr_cnt++;
        last_valid = rx_valid;
    endtask

    task automatic step();
        if (rand_mode) begin
            rx_ready = ($urandom_range(0, 3) == 0);
            ovr_clr  = ($urandom_range(0, 15) == 0);
        end else begin
            rx_ready = (edge_n + 1 == rdy_edge);
            ovr_clr  = (edge_n + 1 == clr_edge0) || (edge_n + 1 == clr_edge1);
        end
        tick();
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) step();
    endtask

    // rst_bit >= 0 aborts the frame with a reset half-way through that bit.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int stop_len,
                              input int rst_bit);
        ev_t ev;
        last_e0 = edge_n + 1;
        new_busy(last_e0 + 2, stop_ok ? last_e0 + LAT : BIG);
        ev.e  = last_e0 + LAT;
        ev.d  = d;
        ev.ok = stop_ok;
        evq.push_back(ev);
        hold(1'b0, N);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) begin
                hold(d[i], N / 2);
                rst = 1'b1;
                rx  = 1'b1;
                step();
                rst = 1'b0;
                return;
            end
            hold(d[i], N);
        end
        hold(stop_ok, stop_len);
    endtask

    // Bad-stop frame followed by a line held low for extra_bits periods.
    task automatic send_break(input logic [7:0] d, input int extra_bits, input int gap);
        send_frame(d, 1'b0, N, -1);
        hold(1'b0, extra_bits * N);
        bhi[1] = edge_n + 1 + 2;
        hold(1'b1, gap);
    endtask

    task automatic glitch(input int len);
        int e0;
        e0 = edge_n + 1;
        new_busy(e0 + 2, e0 + 2 + H);
        hold(1'b0, len);
        hold(1'b1, 12);
    endtask

    task automatic consume();
        rdy_edge = edge_n + 1;
        hold(1'b1, 2);
    endtask

    task automatic clear_obs();
        rise_e.delete();
        rise_d.delete();
        fall_e.delete();
        ferr_cnt = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0a;
        int e0b;
        int nr;
        logic [7:0] d;

        // Reset
        rst = 1'b1;
        rx  = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_data", {24'd0, rx_data}, 32'h0);
        hold(1'b1, 5);

        // 1: single byte, latency from falling edge
        clear_obs();
        send_frame(8'h88, 1'b1, N, -1);
        hold(1'b1, 10);
        nr = rise_e.size();
        check("t1_rises", nr, 1);
        if (nr >= 1) begin
            check("t1_latency", rise_e[0] - last_e0, 154);
            check("t1_data", {24'd0, rise_d[0]}, 32'h88);
        end
        check("t1_ferr_cnt", ferr_cnt, 0);

        // 2: back-to-back, ready pulsed on the edge before the second delivery
        consume();
        clear_obs();
        send_frame(8'h55, 1'b1, N, -1);
        e0a = last_e0;
        rdy_edge = edge_n + 1 + LAT - 1;
        send_frame(8'hA3, 1'b1, N, -1);
        e0b = last_e0;
        hold(1'b1, 10);
        check("t2_gap", e0b - e0a, 10 * N);
        nr = rise_e.size();
        check("t2_rises", nr, 2);
        if (nr >= 2 && fall_e.size() >= 1) begin
            check("t2_data0", {24'd0, rise_d[0]}, 32'h55);
            check("t2_data1", {24'd0, rise_d[1]}, 32'hA3);
            check("t2_low_cycles", rise_e[1] - fall_e[fall_e.size() - 1], 1);
        end

        // 3: overrun with ready held low; clear on the set edge loses
        consume();
        clear_obs();
        send_frame(8'h11, 1'b1, N, -1);
        clr_edge0 = edge_n + 1 + LAT;
        send_frame(8'h22, 1'b1, N, -1);
        hold(1'b1, 10);
        check("t3_data", {24'd0, rx_data}, 32'h11);
        check("t3_ovr_set", {31'd0, overrun}, 32'h1);
        clr_edge1 = edge_n + 1;
        step();
        check("t3_ovr_clr", {31'd0, overrun}, 32'h0);
        consume();

        // 4: short glitch
        clear_obs();
        glitch(4);
        check("t4_rises", rise_e.size(), 0);
        check("t4_ferr_cnt", ferr_cnt, 0);
        check("t4_busy", {31'd0, busy}, 32'h0);

        // 5: framing error, break, then a good byte
        clear_obs();
        send_break(8'h3C, 5, 8);
        check("t5_ferr_cnt", ferr_cnt, 1);
        check("t5_no_valid", rise_e.size(), 0);
        send_frame(8'h7E, 1'b1, N, -1);
        hold(1'b1, 10);
        nr = rise_e.size();
        check("t5_rises", nr, 1);
        if (nr >= 1) check("t5_data", {24'd0, rise_d[0]}, 32'h7E);

        // 6: reset in the middle of the data bits
        clear_obs();
        send_frame(8'h9B, 1'b1, N, 3);
        check("t6_valid", {31'd0, rx_valid}, 32'h0);
        check("t6_data", {24'd0, rx_data}, 32'h0);
        check("t6_busy", {31'd0, busy}, 32'h0);
        check("t6_ferr", {31'd0, frame_err}, 32'h0);
        hold(1'b1, 2 * LAT);
        check("t6_no_byte", rise_e.size(), 0);
        send_frame(8'hC5, 1'b1, N, -1);
        hold(1'b1, 10);
        nr = rise_e.size();
        check("t6_rises", nr, 1);
        if (nr >= 1) check("t6_data_c5", {24'd0, rise_d[0]}, 32'hC5);

        // Minimum stop length before the next start bit
        consume();
        clear_obs();
        send_frame(8'h5A, 1'b1, 9, -1);
        rdy_edge = edge_n + 1 + LAT - 3;
        send_frame(8'h0F, 1'b1, N, -1);
        hold(1'b1, 10);
        nr = rise_e.size();
        check("short_stop_rises", nr, 2);
        if (nr >= 2) begin
            check("short_stop_d0", {24'd0, rise_d[0]}, 32'h5A);
            check("short_stop_d1", {24'd0, rise_d[1]}, 32'h0F);
        end

        // Randomised traffic with random ready and clear
        rand_mode = 1'b1;
        for (int k = 0; k < 24; k++) begin
            d = 8'($urandom);
            case ($urandom_range(0, 9))
                0: glitch($urandom_range(1, 7));
                1: send_break(d, $urandom_range(0, 3), $urandom_range(4, 20));
                default: begin
                    send_frame(d, 1'b1, $urandom_range(9, 16), -1);
                    hold(1'b1, $urandom_range(0, 20));
                end
            endcase
        end
        hold(1'b1, 30);
        rand_mode = 1'b0;
        rdy_edge  = -1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
